// File: rtl/alu_sequencer.sv
// Four-phase (Q1..Q4) PIC16 instruction sequencer driving ALU controls.
// Optional macro ALU_SEQ_SKIP_EN enables DECFSZ/INCFSZ/BTFSC/BTFSS skip generation.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [13:0] instr,
  output logic        instr_ready,
  output logic [3:0]  alu_op,
  output logic        alu_d,
  output logic        alu_d_wr_en,
  output logic        alu_status_wr_en,
  output logic        lf_sel,
  output logic [6:0]  f_addr,
  output logic [7:0]  literal,
  input  logic        alu_z,
  input  logic        bit_test_res,
  output logic [1:0]  phase,
  output logic        busy,
  output logic        skip
);

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_COM    = 4'd5;
  localparam logic [3:0] ALU_RLF    = 4'd6;
  localparam logic [3:0] ALU_RRF    = 4'd7;
  localparam logic [3:0] ALU_SWAPF  = 4'd8;
  localparam logic [3:0] ALU_INC    = 4'd9;
  localparam logic [3:0] ALU_DEC    = 4'd10;
  localparam logic [3:0] ALU_CLR    = 4'd11;
  localparam logic [3:0] ALU_PASSLF = 4'd12;
  localparam logic [3:0] ALU_PASSW  = 4'd13;

`ifdef ALU_SEQ_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, Q1, Q2, Q3, Q4} state_t;
  typedef enum logic [1:0] {SK_NONE, SK_ZERO, SK_BCLR, SK_BSET} skip_t;

  state_t     state;
  skip_t      skip_kind;
  logic       d_en_q;
  logic       st_en_q;

  logic [3:0] dec_op;
  logic       dec_d;
  logic       dec_lf;
  logic       dec_wr;
  logic       dec_st;
  skip_t      dec_sk;
  logic       hs;

  assign hs = instr_valid && instr_ready;

  always_comb begin
    dec_op = ALU_PASSLF;
    dec_d  = instr[7];
    dec_lf = 1'b0;
    dec_wr = 1'b0;
    dec_st = 1'b0;
    dec_sk = SK_NONE;
    case (instr[13:12])
      2'b00: begin
        dec_wr = 1'b1;
        dec_st = 1'b1;
        case (instr[11:8])
          4'b0111: dec_op = ALU_ADD;
          4'b0101: dec_op = ALU_AND;
          4'b0001: dec_op = ALU_CLR;
          4'b1001: dec_op = ALU_COM;
          4'b0011: dec_op = ALU_DEC;
          4'b1011: begin
            dec_op = ALU_DEC;
            dec_st = 1'b0;
            if (SKIP_EN) dec_sk = SK_ZERO;
          end
          4'b1010: dec_op = ALU_INC;
          4'b1111: begin
            dec_op = ALU_INC;
            dec_st = 1'b0;
            if (SKIP_EN) dec_sk = SK_ZERO;
          end
          4'b0100: dec_op = ALU_OR;
          4'b1000: dec_op = ALU_PASSLF;
          4'b0000: begin
            if (instr[7]) begin
              dec_op = ALU_PASSW;
              dec_d  = 1'b1;
              dec_st = 1'b0;
            end else begin
              dec_wr = 1'b0;
              dec_st = 1'b0;
            end
          end
          4'b1101: dec_op = ALU_RLF;
          4'b1100: dec_op = ALU_RRF;
          4'b0010: dec_op = ALU_SUB;
          4'b1110: begin
            dec_op = ALU_SWAPF;
            dec_st = 1'b0;
          end
          default: dec_op = ALU_XOR;
        endcase
      end
      2'b01: begin
        // Bit tests only read the register; BCF/BSF are not sequenced here.
        if (SKIP_EN && instr[11])
          dec_sk = instr[10] ? SK_BSET : SK_BCLR;
      end
      2'b11: begin
        dec_lf = 1'b1;
        dec_d  = 1'b0;
        dec_wr = 1'b1;
        dec_st = 1'b1;
        casez (instr[11:8])
          4'b00??: dec_op = ALU_PASSLF;
          4'b111?: dec_op = ALU_ADD;
          4'b110?: dec_op = ALU_SUB;
          4'b1001: dec_op = ALU_AND;
          4'b1000: dec_op = ALU_OR;
          4'b1010: dec_op = ALU_XOR;
          default: begin
            dec_wr = 1'b0;
            dec_st = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      skip_kind        <= SK_NONE;
      d_en_q           <= 1'b0;
      st_en_q          <= 1'b0;
      instr_ready      <= 1'b0;
      alu_op           <= '0;
      alu_d            <= 1'b0;
      alu_d_wr_en      <= 1'b0;
      alu_status_wr_en <= 1'b0;
      lf_sel           <= 1'b0;
      f_addr           <= '0;
      literal          <= '0;
      phase            <= '0;
      busy             <= 1'b0;
      skip             <= 1'b0;
    end else begin
      alu_d_wr_en      <= 1'b0;
      alu_status_wr_en <= 1'b0;
      skip             <= 1'b0;
      case (state)
        IDLE, Q4: begin
          // instr_ready is registered, so it reads 0 for the first cycle out of reset.
          if (hs) begin
            state       <= Q1;
            phase       <= 2'd0;
            busy        <= 1'b1;
            instr_ready <= 1'b0;
            alu_op      <= dec_op;
            alu_d       <= dec_d;
            lf_sel      <= dec_lf;
            f_addr      <= instr[6:0];
            literal     <= instr[7:0];
            d_en_q      <= dec_wr;
            st_en_q     <= dec_st;
            skip_kind   <= dec_sk;
          end else begin
            state       <= IDLE;
            phase       <= 2'd0;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
          end
        end
        Q1: begin
          state <= Q2;
          phase <= 2'd1;
        end
        Q2: begin
          state            <= Q3;
          phase            <= 2'd2;
          alu_d_wr_en      <= d_en_q;
          alu_status_wr_en <= st_en_q;
        end
        Q3: begin
          state       <= Q4;
          phase       <= 2'd3;
          instr_ready <= 1'b1;
          case (skip_kind)
            SK_ZERO: skip <= SKIP_EN && alu_z;
            SK_BCLR: skip <= SKIP_EN && !bit_test_res;
            SK_BSET: skip <= SKIP_EN && bit_test_res;
            default: skip <= 1'b0;
          endcase
        end
        default: begin
          state       <= IDLE;
          phase       <= 2'd0;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer; expected values hand-derived per instruction.
// Skip expectations follow whether ALU_SEQ_SKIP_EN is defined for the build.
module tb_alu_sequencer;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_RLF    = 4'd6;
  localparam logic [3:0] OP_SWAPF  = 4'd8;
  localparam logic [3:0] OP_INC    = 4'd9;
  localparam logic [3:0] OP_DEC    = 4'd10;
  localparam logic [3:0] OP_CLR    = 4'd11;
  localparam logic [3:0] OP_PASSLF = 4'd12;
  localparam logic [3:0] OP_PASSW  = 4'd13;

`ifdef ALU_SEQ_SKIP_EN
  localparam logic SKIP_ON = 1'b1;
`else
  localparam logic SKIP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [13:0] instr;
  logic        instr_ready;
  logic [3:0]  alu_op;
  logic        alu_d;
  logic        alu_d_wr_en;
  logic        alu_status_wr_en;
  logic        lf_sel;
  logic [6:0]  f_addr;
  logic [7:0]  literal;
  logic        alu_z;
  logic        bit_test_res;
  logic [1:0]  phase;
  logic        busy;
  logic        skip;

  int total = 0;
  int bad   = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_d(alu_d),
    .alu_d_wr_en(alu_d_wr_en), .alu_status_wr_en(alu_status_wr_en),
    .lf_sel(lf_sel), .f_addr(f_addr), .literal(literal), .alu_z(alu_z),
    .bit_test_res(bit_test_res), .phase(phase), .busy(busy), .skip(skip)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b1; instr = 14'h0783; alu_z = 1'b0; bit_test_res = 1'b0;
    step();
    step();
    rst = 1'b0; instr_valid = 1'b0;
    total++;
    if ({instr_ready, busy, phase, alu_op, alu_d, alu_d_wr_en, alu_status_wr_en, lf_sel, f_addr, literal, skip} !== 29'd0) begin
      bad++; $display("FAIL reset_outputs: got ready=%b busy=%b phase=%0d op=%0d wr=%b%b skip=%b, need all 0",
                      instr_ready, busy, phase, alu_op, alu_d_wr_en, alu_status_wr_en, skip);
    end
    step();
    total++;
    if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle_ready: got ready=%b busy=%b, need 1 0", instr_ready, busy);
    end
  endtask

  task automatic test_addwf();
    instr_valid = 1'b1; instr = 14'h0783;
    step();
    // Q1; offer an unrelated word that must be ignored outside a handshake
    instr = 14'h3FFF;
    total++;
    if (alu_op !== OP_ADD || alu_d !== 1'b1 || f_addr !== 7'h03 || lf_sel !== 1'b0 || phase !== 2'd0 || busy !== 1'b1 || instr_ready !== 1'b0) begin
      bad++; $display("FAIL addwf_q1: got op=%0d d=%b f=%h lf=%b ph=%0d busy=%b rdy=%b, need 0 1 03 0 0 1 0",
                      alu_op, alu_d, f_addr, lf_sel, phase, busy, instr_ready);
    end
    total++;
    if (alu_d_wr_en !== 1'b0 || alu_status_wr_en !== 1'b0) begin
      bad++; $display("FAIL addwf_q1_wr: got %b%b, need 00", alu_d_wr_en, alu_status_wr_en);
    end
    step();
    total++;
    if (phase !== 2'd1 || alu_d_wr_en !== 1'b0 || instr_ready !== 1'b0) begin
      bad++; $display("FAIL addwf_q2: got ph=%0d wr=%b rdy=%b, need 1 0 0", phase, alu_d_wr_en, instr_ready);
    end
    instr_valid = 1'b0;
    step();
    total++;
    if (phase !== 2'd2 || alu_d_wr_en !== 1'b1 || alu_status_wr_en !== 1'b1 || f_addr !== 7'h03 || alu_op !== OP_ADD) begin
      bad++; $display("FAIL addwf_q3: got ph=%0d wr=%b%b f=%h op=%0d, need 2 11 03 0",
                      phase, alu_d_wr_en, alu_status_wr_en, f_addr, alu_op);
    end
    step();
    total++;
    if (phase !== 2'd3 || instr_ready !== 1'b1 || alu_d_wr_en !== 1'b0 || alu_status_wr_en !== 1'b0 || skip !== 1'b0) begin
      bad++; $display("FAIL addwf_q4: got ph=%0d rdy=%b wr=%b%b skip=%b, need 3 1 00 0",
                      phase, instr_ready, alu_d_wr_en, alu_status_wr_en, skip);
    end
    step();
    total++;
    if (busy !== 1'b0 || phase !== 2'd0 || instr_ready !== 1'b1 || alu_op !== OP_ADD) begin
      bad++; $display("FAIL addwf_idle: got busy=%b ph=%0d rdy=%b op=%0d, need 0 0 1 0", busy, phase, instr_ready, alu_op);
    end
  endtask

  task automatic test_decode();
    logic [13:0] v_instr [6] = '{14'h0583, 14'h0183, 14'h0E83, 14'h0D03, 14'h3A0F, 14'h0A85};
    logic [3:0]  v_op    [6] = '{OP_AND, OP_CLR, OP_SWAPF, OP_RLF, OP_XOR, OP_INC};
    logic        v_d     [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        v_lf    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        v_st    [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      instr_valid = 1'b1; instr = v_instr[i];
      step();
      instr_valid = 1'b0;
      total++;
      if (alu_op !== v_op[i] || alu_d !== v_d[i] || lf_sel !== v_lf[i] || literal !== v_instr[i][7:0]) begin
        bad++; $display("FAIL decode_%0d: got op=%0d d=%b lf=%b lit=%h, need %0d %b %b %h",
                        i, alu_op, alu_d, lf_sel, literal, v_op[i], v_d[i], v_lf[i], v_instr[i][7:0]);
      end
      step(); step();
      total++;
      if (alu_d_wr_en !== 1'b1 || alu_status_wr_en !== v_st[i]) begin
        bad++; $display("FAIL decode_wr_%0d: got %b%b, need 1%b", i, alu_d_wr_en, alu_status_wr_en, v_st[i]);
      end
      step(); step();
    end
  endtask

  task automatic test_back_to_back();
    int cycles = 0;
    instr_valid = 1'b1; instr = 14'h3E05;
    step(); cycles++;
    instr_valid = 1'b0;
    total++;
    if (alu_op !== OP_ADD || lf_sel !== 1'b1 || alu_d !== 1'b0 || literal !== 8'h05) begin
      bad++; $display("FAIL b2b_addlw: got op=%0d lf=%b d=%b lit=%h, need 0 1 0 05", alu_op, lf_sel, alu_d, literal);
    end
    step(); step(); step(); cycles += 3;
    total++;
    if (instr_ready !== 1'b1 || phase !== 2'd3) begin
      bad++; $display("FAIL b2b_q4_ready: got rdy=%b ph=%0d, need 1 3", instr_ready, phase);
    end
    instr_valid = 1'b1; instr = 14'h3005;
    step(); cycles++;
    instr_valid = 1'b0;
    total++;
    if (phase !== 2'd0 || busy !== 1'b1 || alu_op !== OP_PASSLF || lf_sel !== 1'b1 || literal !== 8'h05 || instr_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_movlw_q1: got ph=%0d busy=%b op=%0d lf=%b lit=%h rdy=%b, need 0 1 12 1 05 0",
                      phase, busy, alu_op, lf_sel, literal, instr_ready);
    end
    step(); step(); cycles += 2;
    total++;
    if (alu_d_wr_en !== 1'b1 || alu_status_wr_en !== 1'b1) begin
      bad++; $display("FAIL b2b_movlw_q3: got %b%b, need 11", alu_d_wr_en, alu_status_wr_en);
    end
    step(); cycles++;
    total++;
    if (phase !== 2'd3 || busy !== 1'b1 || cycles !== 8) begin
      bad++; $display("FAIL b2b_length: got ph=%0d busy=%b cycles=%0d, need 3 1 8", phase, busy, cycles);
    end
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: got busy=%b, need 0", busy);
    end
  endtask

  task automatic test_skip_decfsz();
    for (int z = 1; z >= 0; z--) begin
      instr_valid = 1'b1; instr = 14'h0B84;
      step();
      instr_valid = 1'b0;
      total++;
      if (alu_op !== OP_DEC || alu_d !== 1'b1 || f_addr !== 7'h04) begin
        bad++; $display("FAIL decfsz_decode: got op=%0d d=%b f=%h, need 10 1 04", alu_op, alu_d, f_addr);
      end
      step(); step();
      alu_z = z[0];
      total++;
      if (alu_d_wr_en !== 1'b1 || alu_status_wr_en !== 1'b0 || skip !== 1'b0) begin
        bad++; $display("FAIL decfsz_q3: got wr=%b%b skip=%b, need 10 0", alu_d_wr_en, alu_status_wr_en, skip);
      end
      step();
      alu_z = 1'b0;
      total++;
      if (skip !== (SKIP_ON & z[0])) begin
        bad++; $display("FAIL decfsz_skip_z%0d: got %b, need %b", z, skip, SKIP_ON & z[0]);
      end
      step();
      total++;
      if (skip !== 1'b0) begin
        bad++; $display("FAIL decfsz_skip_clear: got %b, need 0", skip);
      end
    end
  endtask

  task automatic test_bit_tests();
    logic [13:0] v_instr [3] = '{14'h1C05, 14'h1805, 14'h1805};
    logic        v_bit   [3] = '{1'b1, 1'b0, 1'b1};
    logic        v_skip  [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1; instr = v_instr[i];
      step();
      instr_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        total++;
        if (alu_d_wr_en !== 1'b0 || alu_status_wr_en !== 1'b0) begin
          bad++; $display("FAIL bittest_%0d_wr_c%0d: got %b%b, need 00", i, c, alu_d_wr_en, alu_status_wr_en);
        end
        if (c == 1) bit_test_res = v_bit[i];
        step();
      end
      bit_test_res = 1'b0;
      total++;
      if (skip !== (SKIP_ON & v_skip[i]) || alu_d_wr_en !== 1'b0) begin
        bad++; $display("FAIL bittest_%0d_skip: got skip=%b wr=%b, need %b 0", i, skip, alu_d_wr_en, SKIP_ON & v_skip[i]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    instr_valid = 1'b1; instr = 14'h0080;
    step();
    instr_valid = 1'b0;
    total++;
    if (alu_op !== OP_PASSW || alu_d !== 1'b1 || f_addr !== 7'h00) begin
      bad++; $display("FAIL movwf_decode: got op=%0d d=%b f=%h, need 13 1 00", alu_op, alu_d, f_addr);
    end
    step();
    rst = 1'b1;
    step();
    total++;
    if ({instr_ready, busy, phase, alu_op, alu_d, alu_d_wr_en, alu_status_wr_en, lf_sel, f_addr, literal, skip} !== 29'd0) begin
      bad++; $display("FAIL reset_mid: got ready=%b busy=%b phase=%0d op=%0d wr=%b%b, need all 0",
                      instr_ready, busy, phase, alu_op, alu_d_wr_en, alu_status_wr_en);
    end
    rst = 1'b0;
    step();
    total++;
    if (alu_d_wr_en !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_after: got wr=%b busy=%b rdy=%b, need 0 0 1", alu_d_wr_en, busy, instr_ready);
    end
    // reset wins over a simultaneous handshake
    instr_valid = 1'b1; instr = 14'h0783; rst = 1'b1;
    step();
    rst = 1'b0; instr_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || alu_op !== 4'd0 || f_addr !== 7'h00) begin
      bad++; $display("FAIL reset_vs_handshake: got busy=%b op=%0d f=%h, need 0 0 00", busy, alu_op, f_addr);
    end
    step();
  endtask

  task automatic test_call_nop();
    alu_z = 1'b1; bit_test_res = 1'b1;
    instr_valid = 1'b1; instr = 14'h2005;
    step();
    instr_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (alu_d_wr_en !== 1'b0 || alu_status_wr_en !== 1'b0 || skip !== 1'b0 || busy !== 1'b1 || phase !== c[1:0]) begin
        bad++; $display("FAIL call_c%0d: got wr=%b%b skip=%b busy=%b ph=%0d, need 00 0 1 %0d",
                        c, alu_d_wr_en, alu_status_wr_en, skip, busy, phase, c);
      end
      step();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL call_idle: got busy=%b, need 0", busy);
    end
    alu_z = 1'b0; bit_test_res = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addwf();
    test_decode();
    test_back_to_back();
    test_skip_decfsz();
    test_bit_tests();
    test_reset_mid();
    test_call_nop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
